id_ex_stage: RTL and testbench

//  ID/EX pipeline stage of the RISC-V pipeline, directly downstream of the register file.

---
 rtl/id_ex_stage_pkg.sv | 41 ++++
 rtl/id_ex_stage_if.sv | 52 +++++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the RISC-V ID/EX stage: control bundle, ALU ops, defaults.
package riscv_pipe_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_SLL  = 4'd2,
    ALU_OP_SLT  = 4'd3,
    ALU_OP_SLTU = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_OR   = 4'd8,
    ALU_OP_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  // A bubble: no architectural side effects at all.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    alu_op:     ALU_OP_ADD
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, EX-side outputs and stall/flush controls around the ID/EX register.
interface id_ex_stage_if
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             id_valid_i;
  logic [XLEN-1:0]  id_pc_i;
  logic [4:0]       id_rs_addr_i;
  logic [4:0]       id_rt_addr_i;
  logic             id_rt_used_i;
  logic [4:0]       id_rd_addr_i;
  logic [XLEN-1:0]  id_rs_data_i;
  logic [XLEN-1:0]  id_rt_data_i;
  logic [XLEN-1:0]  id_imm_i;
  ctrl_t            id_ctrl_i;
  logic             ex_flush_i;
  logic             mem_stall_i;

  logic             stall_o;
  logic             ex_valid_o;
  logic [XLEN-1:0]  ex_pc_o;
  logic [XLEN-1:0]  ex_rs_data_o;
  logic [XLEN-1:0]  ex_rt_data_o;
  logic [XLEN-1:0]  ex_imm_o;
  logic [4:0]       ex_rs_addr_o;
  logic [4:0]       ex_rt_addr_o;
  logic [4:0]       ex_rd_addr_o;
  ctrl_t            ex_ctrl_o;
  logic [CNT_W-1:0] stall_cnt_o;

  // Upstream decode logic (or a bench) drives ID fields and watches EX/stall.
  modport master (
    output id_valid_i, id_pc_i, id_rs_addr_i, id_rt_addr_i, id_rt_used_i,
           id_rd_addr_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_ctrl_i,
           ex_flush_i, mem_stall_i,
    input  stall_o, ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
           ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o, ex_ctrl_o, stall_cnt_o
  );

  // The ID/EX stage itself.
  modport slave (
    input  id_valid_i, id_pc_i, id_rs_addr_i, id_rt_addr_i, id_rt_used_i,
           id_rd_addr_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_ctrl_i,
           ex_flush_i, mem_stall_i,
    output stall_o, ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
           ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o, ex_ctrl_o, stall_cnt_o
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load sitting in EX whose rd is read by the instruction in ID.
module hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rt_used,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_flush,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  // x0 is never a real dependency; a taken branch kills the ID instruction so no stall is needed.
  always_comb begin
    rs_match = (ex_rd_addr == id_rs_addr);
    rt_match = id_rt_used && (ex_rd_addr == id_rt_addr);
    load_use = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != 5'd0)
               && (rs_match || rt_match) && !ex_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, memory freeze and stall counter.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic             load_use;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs_data;
  logic [XLEN-1:0]  ex_rt_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs_addr;
  logic [4:0]       ex_rt_addr;
  logic [4:0]       ex_rd_addr;
  ctrl_t            ex_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  hazard_detect u_hazard (
    .id_valid    (bus.id_valid_i),
    .id_rs_addr  (bus.id_rs_addr_i),
    .id_rt_addr  (bus.id_rt_addr_i),
    .id_rt_used  (bus.id_rt_used_i),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .ex_flush    (bus.ex_flush_i),
    .load_use    (load_use)
  );

  assign bus.stall_o = bus.mem_stall_i | load_use;

  // EX register priority: reset, memory freeze, bubble on flush/load-use, else capture ID.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rd_addr <= '0;
      ex_ctrl    <= CTRL_NOP;
    end else if (bus.mem_stall_i) begin
      ex_valid   <= ex_valid;
      ex_pc      <= ex_pc;
      ex_rs_data <= ex_rs_data;
      ex_rt_data <= ex_rt_data;
      ex_imm     <= ex_imm;
      ex_rs_addr <= ex_rs_addr;
      ex_rt_addr <= ex_rt_addr;
      ex_rd_addr <= ex_rd_addr;
      ex_ctrl    <= ex_ctrl;
    end else if (bus.ex_flush_i || load_use) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rd_addr <= '0;
      ex_ctrl    <= CTRL_NOP;
    end else begin
      ex_valid   <= bus.id_valid_i;
      ex_pc      <= bus.id_pc_i;
      ex_rs_data <= bus.id_rs_data_i;
      ex_rt_data <= bus.id_rt_data_i;
      ex_imm     <= bus.id_imm_i;
      ex_rs_addr <= bus.id_rs_addr_i;
      ex_rt_addr <= bus.id_rt_addr_i;
      ex_rd_addr <= bus.id_rd_addr_i;
      ex_ctrl    <= bus.id_valid_i ? bus.id_ctrl_i : CTRL_NOP;
    end
  end

  // Count cycles actually lost to load-use hazards, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cnt <= '0;
    end else if (load_use && !bus.mem_stall_i && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.ex_valid_o   = ex_valid;
  assign bus.ex_pc_o      = ex_pc;
  assign bus.ex_rs_data_o = ex_rs_data;
  assign bus.ex_rt_data_o = ex_rt_data;
  assign bus.ex_imm_o     = ex_imm;
  assign bus.ex_rs_addr_o = ex_rs_addr;
  assign bus.ex_rt_addr_o = ex_rt_addr;
  assign bus.ex_rd_addr_o = ex_rd_addr;
  assign bus.ex_ctrl_o    = ex_ctrl;
  assign bus.stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by biased random traffic.
module tb_id_ex_stage;
  import riscv_pipe_pkg::*;

  localparam int TB_XLEN  = 32;
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  int tests  = 0;
  int failed = 0;

  // Reference model of the EX register contents.
  logic        m_valid;
  logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  ctrl_t       m_ctrl;
  int          m_cnt;

  id_ex_stage_if #(.XLEN(TB_XLEN), .CNT_W(TB_CNT_W)) bus ();

  id_ex_stage #(.XLEN(TB_XLEN), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs, input logic [4:0] rt, input logic rt_used,
                               input logic [4:0] rd, input logic [31:0] rs_data,
                               input logic [31:0] rt_data, input logic [31:0] imm,
                               input ctrl_t ctrl, input logic flush, input logic mstall);
    bus.id_valid_i   = valid;
    bus.id_pc_i      = pc;
    bus.id_rs_addr_i = rs;
    bus.id_rt_addr_i = rt;
    bus.id_rt_used_i = rt_used;
    bus.id_rd_addr_i = rd;
    bus.id_rs_data_i = rs_data;
    bus.id_rt_data_i = rt_data;
    bus.id_imm_i     = imm;
    bus.id_ctrl_i    = ctrl;
    bus.ex_flush_i   = flush;
    bus.mem_stall_i  = mstall;
  endtask

  function automatic ctrl_t randCtrl(input logic mem_read);
    ctrl_t c;
    c.reg_write  = 1'($urandom);
    c.mem_read   = mem_read;
    c.mem_write  = 1'($urandom);
    c.mem_to_reg = 1'($urandom);
    c.alu_src    = 1'($urandom);
    c.branch     = 1'($urandom);
    c.alu_op     = alu_op_e'(4'($urandom_range(0, 9)));
    return c;
  endfunction

  function automatic ctrl_t loadCtrl();
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write  = 1'b1;
    c.mem_read   = 1'b1;
    c.mem_to_reg = 1'b1;
    c.alu_src    = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t aluCtrl();
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write = 1'b1;
    return c;
  endfunction

  task automatic randomStimulus(input int flush_pct, input int mstall_pct);
    applyStimulus(($urandom_range(0, 99) < 85), $urandom, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom, randCtrl(1'($urandom)),
                  ($urandom_range(0, 99) < flush_pct), ($urandom_range(0, 99) < mstall_pct));
  endtask

  // One clock: check the combinational stall, advance the model, check the registered outputs.
  task automatic runCycle(input int exp_stall);
    logic lu;
    logic exp_st;
    #1;
    lu = bus.id_valid_i && m_valid && m_ctrl.mem_read && (m_rd != 5'd0)
         && ((m_rd == bus.id_rs_addr_i) || (bus.id_rt_used_i && (m_rd == bus.id_rt_addr_i)))
         && !bus.ex_flush_i;
    exp_st = bus.mem_stall_i || lu;
    checkOutput("stall_o", 32'(bus.stall_o), 32'(exp_st));
    if (exp_stall >= 0) checkOutput("stall_directed", 32'(bus.stall_o), 32'(exp_stall));
    @(posedge clk);
    if (rst_n) begin
      m_valid = 0; m_pc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = CTRL_NOP; m_cnt = 0;
    end else if (!bus.mem_stall_i) begin
      if (lu && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (bus.ex_flush_i || lu) begin
        m_valid = 0; m_pc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = CTRL_NOP;
      end else begin
        m_valid = bus.id_valid_i; m_pc = bus.id_pc_i;
        m_rs_data = bus.id_rs_data_i; m_rt_data = bus.id_rt_data_i; m_imm = bus.id_imm_i;
        m_rs = bus.id_rs_addr_i; m_rt = bus.id_rt_addr_i; m_rd = bus.id_rd_addr_i;
        m_ctrl = bus.id_valid_i ? bus.id_ctrl_i : CTRL_NOP;
      end
    end
    #1;
    checkOutput("ex_valid", 32'(bus.ex_valid_o), 32'(m_valid));
    checkOutput("ex_pc", bus.ex_pc_o, m_pc);
    checkOutput("ex_rs_data", bus.ex_rs_data_o, m_rs_data);
    checkOutput("ex_rt_data", bus.ex_rt_data_o, m_rt_data);
    checkOutput("ex_imm", bus.ex_imm_o, m_imm);
    checkOutput("ex_rs_addr", 32'(bus.ex_rs_addr_o), 32'(m_rs));
    checkOutput("ex_rt_addr", 32'(bus.ex_rt_addr_o), 32'(m_rt));
    checkOutput("ex_rd_addr", 32'(bus.ex_rd_addr_o), 32'(m_rd));
    checkOutput("ex_ctrl", 32'(bus.ex_ctrl_o), 32'(m_ctrl));
    checkOutput("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_cnt));
    if (!bus.ex_valid_o) begin
      checkOutput("bubble_reg_write", 32'(bus.ex_ctrl_o.reg_write), 32'd0);
      checkOutput("bubble_mem_write", 32'(bus.ex_ctrl_o.mem_write), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    m_valid = 0; m_pc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = CTRL_NOP; m_cnt = 0;

    // Reset held for two checked cycles with random ID traffic.
    rst_n = 1'b1;
    randomStimulus(0, 0);
    @(posedge clk);
    @(negedge clk);
    randomStimulus(0, 0);
    runCycle(0);
    randomStimulus(0, 0);
    runCycle(0);
    checkOutput("reset_valid", 32'(bus.ex_valid_o), 32'd0);
    checkOutput("reset_cnt", 32'(bus.stall_cnt_o), 32'd0);
    rst_n = 1'b0;

    // Plain pass-through.
    applyStimulus(1, 32'h100, 5'd1, 5'd2, 1, 5'd5, 32'hDEADBEEF, 32'h12345678, 32'h4,
                  aluCtrl(), 0, 0);
    runCycle(0);
    checkOutput("pass_pc", bus.ex_pc_o, 32'h100);
    checkOutput("pass_rs_data", bus.ex_rs_data_o, 32'hDEADBEEF);
    checkOutput("pass_rd", 32'(bus.ex_rd_addr_o), 32'd5);
    checkOutput("pass_valid", 32'(bus.ex_valid_o), 32'd1);

    // lw x7 then add x8,x7,x1: one bubble, then the add enters.
    applyStimulus(1, 32'h104, 5'd2, 5'd0, 0, 5'd7, 32'h11, 32'h0, 32'h8, loadCtrl(), 0, 0);
    runCycle(0);
    applyStimulus(1, 32'h108, 5'd7, 5'd1, 1, 5'd8, 32'h22, 32'h33, 32'h0, aluCtrl(), 0, 0);
    runCycle(1);
    checkOutput("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
    checkOutput("lu_cnt", 32'(bus.stall_cnt_o), 32'd1);
    runCycle(0);
    checkOutput("lu_add_rd", 32'(bus.ex_rd_addr_o), 32'd8);
    checkOutput("lu_add_valid", 32'(bus.ex_valid_o), 32'd1);

    // lw x0 never stalls and is passed through; addi does not read rs2.
    applyStimulus(1, 32'h10C, 5'd3, 5'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, loadCtrl(), 0, 0);
    runCycle(0);
    checkOutput("lw_x0_mem_read", 32'(bus.ex_ctrl_o.mem_read), 32'd1);
    applyStimulus(1, 32'h110, 5'd0, 5'd0, 1, 5'd9, 32'h0, 32'h0, 32'h0, aluCtrl(), 0, 0);
    runCycle(0);
    applyStimulus(1, 32'h114, 5'd2, 5'd0, 0, 5'd7, 32'h0, 32'h0, 32'h0, loadCtrl(), 0, 0);
    runCycle(0);
    applyStimulus(1, 32'h118, 5'd3, 5'd7, 0, 5'd8, 32'h0, 32'h0, 32'h5, aluCtrl(), 0, 0);
    runCycle(0);

    // Flush wins over a load-use condition.
    applyStimulus(1, 32'h11C, 5'd2, 5'd0, 0, 5'd7, 32'h0, 32'h0, 32'h0, loadCtrl(), 0, 0);
    runCycle(0);
    applyStimulus(1, 32'h120, 5'd7, 5'd1, 1, 5'd8, 32'h0, 32'h0, 32'h0, aluCtrl(), 1, 0);
    runCycle(0);
    checkOutput("flush_valid", 32'(bus.ex_valid_o), 32'd0);
    checkOutput("flush_cnt", 32'(bus.stall_cnt_o), 32'd1);

    // Memory stall freezes EX for three cycles while ID changes.
    applyStimulus(1, 32'h124, 5'd1, 5'd2, 1, 5'd9, 32'h0, 32'h0, 32'h0, loadCtrl(), 0, 0);
    runCycle(0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h200 + 32'(i * 4), 5'(i + 1), 5'd4, 1, 5'(i + 11), $urandom,
                    $urandom, $urandom, aluCtrl(), 0, 1);
      runCycle(1);
      checkOutput("mstall_rd_held", 32'(bus.ex_rd_addr_o), 32'd9);
    end
    applyStimulus(1, 32'h300, 5'd4, 5'd5, 1, 5'd10, 32'h0, 32'h0, 32'h0, aluCtrl(), 0, 0);
    runCycle(0);
    checkOutput("mstall_release_rd", 32'(bus.ex_rd_addr_o), 32'd10);

    // Biased random traffic, including occasional reset and counter saturation.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) < 2);
      randomStimulus(10, 15);
      runCycle(-1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
